booth_mult_arbiter: RTL and testbench



---
 rtl/booth_mult_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_booth_mult_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : booth_mult_arbiter
// Description : Round-robin arbiter/sequencer sharing one Booth multiplier
//               among NREQ requesters, with a watchdog abort on WAIT.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_mult_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [NREQ-1:0]         Req,
  input  logic [NREQ*WIDTH-1:0]   A_in,
  input  logic [NREQ*WIDTH-1:0]   B_in,
  output logic [NREQ-1:0]         Ack,
  output logic [NREQ-1:0]         ResultValid,
  output logic [2*WIDTH-1:0]      Result,
  output logic                    Error,
  output logic                    Busy,
  output logic                    MulStart,
  output logic [WIDTH-1:0]        MulA,
  output logic [WIDTH-1:0]        MulB,
  input  logic                    MulDone,
  input  logic [2*WIDTH-1:0]      MulProduct
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int PW = 2 * WIDTH;

  localparam logic [LW-1:0] c_LAST_RST = LW'(NREQ - 1);
  localparam logic [CW-1:0] c_CNT_MAX  = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [NREQ-1:0]   r_ack, w_ack_nxt;
  logic [NREQ-1:0]   r_rv, w_rv_nxt;
  logic [PW-1:0]     r_result, w_result_nxt;
  logic              r_error, w_error_nxt;
  logic              r_mulstart, w_mulstart_nxt;
  logic [WIDTH-1:0]  r_mula, w_mula_nxt;
  logic [WIDTH-1:0]  r_mulb, w_mulb_nxt;
  logic [LW-1:0]     r_last, w_last_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;

  logic              w_found;
  logic [LW-1:0]     w_gnt;
  logic [LW-1:0]     w_cand;
  int                w_idx;
  logic [NREQ-1:0]   w_gnt_oh;
  logic [NREQ-1:0]   w_last_oh;
  logic [WIDTH-1:0]  w_opa;
  logic [WIDTH-1:0]  w_opb;

  // Walk the offsets from farthest to nearest so the nearest set bit after
  // r_last is the one left standing.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = r_last;
    w_idx   = 0;
    w_cand  = '0;
    for (int k = NREQ; k >= 1; k--) begin
      w_idx = int'(r_last) + k;
      if (w_idx >= NREQ) begin
        w_idx = w_idx - NREQ;
      end
      w_cand = LW'(w_idx);
      if (Req[w_cand]) begin
        w_found = 1'b1;
        w_gnt   = w_cand;
      end
    end
  end

  always_comb begin
    w_gnt_oh  = '0;
    w_last_oh = '0;
    w_opa     = '0;
    w_opb     = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_gnt_oh[i]  = (w_gnt == LW'(i));
      w_last_oh[i] = (r_last == LW'(i));
      if (w_gnt == LW'(i)) begin
        w_opa = A_in[i*WIDTH +: WIDTH];
        w_opb = B_in[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_ack_nxt      = '0;
    w_rv_nxt       = '0;
    w_result_nxt   = r_result;
    w_error_nxt    = r_error;
    w_mulstart_nxt = 1'b0;
    w_mula_nxt     = r_mula;
    w_mulb_nxt     = r_mulb;
    w_last_nxt     = r_last;
    w_cnt_nxt      = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_ack_nxt      = w_gnt_oh;
          w_mulstart_nxt = 1'b1;
          w_mula_nxt     = w_opa;
          w_mulb_nxt     = w_opb;
          w_last_nxt     = w_gnt;
          w_state_nxt    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // Completion takes precedence over the watchdog on the same cycle.
        if (MulDone) begin
          w_result_nxt = MulProduct;
          w_error_nxt  = 1'b0;
          w_rv_nxt     = w_last_oh;
          w_state_nxt  = S_IDLE;
        end else if (r_cnt == c_CNT_MAX) begin
          w_result_nxt = '0;
          w_error_nxt  = 1'b1;
          w_rv_nxt     = w_last_oh;
          w_state_nxt  = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_ack      <= '0;
      r_rv       <= '0;
      r_result   <= '0;
      r_error    <= 1'b0;
      r_mulstart <= 1'b0;
      r_mula     <= '0;
      r_mulb     <= '0;
      r_last     <= c_LAST_RST;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ack      <= w_ack_nxt;
      r_rv       <= w_rv_nxt;
      r_result   <= w_result_nxt;
      r_error    <= w_error_nxt;
      r_mulstart <= w_mulstart_nxt;
      r_mula     <= w_mula_nxt;
      r_mulb     <= w_mulb_nxt;
      r_last     <= w_last_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  assign Ack         = r_ack;
  assign ResultValid = r_rv;
  assign Result      = r_result;
  assign Error       = r_error;
  assign MulStart    = r_mulstart;
  assign MulA        = r_mula;
  assign MulB        = r_mulb;
  assign Busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_booth_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_mult_arbiter
// Description : Directed bench with a transaction-level reference model and
//               a behavioural multiplier with programmable done latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_mult_arbiter;

  localparam int NREQ    = 4;
  localparam int WIDTH   = 16;
  localparam int TIMEOUT = 64;
  localparam int PW      = 2 * WIDTH;

  logic                  Clock = 1'b0;
  logic                  Reset = 1'b1;
  logic [NREQ-1:0]       Req = '0;
  logic [WIDTH-1:0]      a_arr [NREQ];
  logic [WIDTH-1:0]      b_arr [NREQ];
  logic [NREQ*WIDTH-1:0] A_in, B_in;
  logic                  MulDone = 1'b0;
  logic [PW-1:0]         MulProduct = '0;
  logic [NREQ-1:0]       Ack, ResultValid;
  logic [PW-1:0]         Result;
  logic                  Error, Busy, MulStart;
  logic [WIDTH-1:0]      MulA, MulB;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mul_lat = 0;
  int done_at = -1;
  int t_issue = 0;
  logic chk_en = 1'b0;
  logic signed [PW-1:0] sa, sb;

  // reference model: one operation in flight, timed in absolute cycles
  logic            m_busy = 1'b0;
  int              m_issue = 0;
  int              m_g = 0;
  int              m_last = NREQ - 1;
  logic [NREQ-1:0] e_ack = '0, e_rv = '0;
  logic [PW-1:0]   e_result = '0;
  logic            e_error = 1'b0, e_ms = 1'b0;
  logic [WIDTH-1:0] e_mula = '0, e_mulb = '0;

  int          dut_gnt[$];
  int          mdl_gnt[$];
  int          ack_cyc[$];
  logic [PW-1:0] rv_res[$];

  for (genvar i = 0; i < NREQ; i++) begin : g_pack
    assign A_in[i*WIDTH +: WIDTH] = a_arr[i];
    assign B_in[i*WIDTH +: WIDTH] = b_arr[i];
  end

  booth_mult_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .Clock(Clock), .Reset(Reset), .Req(Req), .A_in(A_in), .B_in(B_in),
    .Ack(Ack), .ResultValid(ResultValid), .Result(Result), .Error(Error),
    .Busy(Busy), .MulStart(MulStart), .MulA(MulA), .MulB(MulB),
    .MulDone(MulDone), .MulProduct(MulProduct)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  always @(posedge Clock) begin
    if (Reset) begin
      m_busy = 1'b0; m_last = NREQ - 1;
      e_ack = '0; e_rv = '0; e_result = '0; e_error = 1'b0; e_ms = 1'b0;
      e_mula = '0; e_mulb = '0;
    end else begin
      e_ack = '0; e_ms = 1'b0; e_rv = '0;
      if (!m_busy) begin
        if (Req != '0) begin
          m_g = -1;
          for (int k = 1; k <= NREQ; k++)
            if (m_g < 0 && Req[(m_last + k) % NREQ]) m_g = (m_last + k) % NREQ;
          e_ack = NREQ'(1) << m_g;
          e_ms = 1'b1; e_mula = a_arr[m_g]; e_mulb = b_arr[m_g];
          m_last = m_g; m_busy = 1'b1; m_issue = cyc + 1;
          mdl_gnt.push_back(m_g);
        end
      end else if (cyc > m_issue) begin
        if (MulDone) begin
          e_rv = NREQ'(1) << m_g; e_result = MulProduct; e_error = 1'b0; m_busy = 1'b0;
        end else if (cyc == m_issue + TIMEOUT) begin
          e_rv = NREQ'(1) << m_g; e_result = '0; e_error = 1'b1; m_busy = 1'b0;
        end
      end
    end
    // behavioural multiplier: done pulse mul_lat cycles after the start cycle
    if (MulStart === 1'b1) begin
      done_at = (mul_lat > 0) ? cyc + mul_lat : -1;
      sa = $signed(MulA); sb = $signed(MulB);
      MulProduct = sa * sb;
    end
    cyc++;
  end

  always @(negedge Clock) begin
    MulDone = (done_at >= 0) && (cyc == done_at);
    if (chk_en) begin
      chk("Ack", 64'(Ack), 64'(e_ack));
      chk("ResultValid", 64'(ResultValid), 64'(e_rv));
      chk("Result", 64'(Result), 64'(e_result));
      chk("Error", 64'(Error), 64'(e_error));
      chk("Busy", 64'(Busy), 64'(m_busy));
      chk("MulStart", 64'(MulStart), 64'(e_ms));
      chk("MulA", 64'(MulA), 64'(e_mula));
      chk("MulB", 64'(MulB), 64'(e_mulb));
      if (Ack != '0) begin
        for (int j = 0; j < NREQ; j++) if (Ack[j]) dut_gnt.push_back(j);
        ack_cyc.push_back(cyc);
      end
      if (ResultValid != '0) rv_res.push_back(Result);
    end
  end

  task automatic wait_ack(input int maxc, output int idx);
    idx = -1;
    for (int i = 0; i < maxc && idx < 0; i++) begin
      @(negedge Clock);
      for (int j = 0; j < NREQ; j++) if (Ack[j]) idx = j;
    end
    t_issue = cyc;
    if (idx < 0) begin
      checks++; errors++;
      $display("FAIL ack_wait: got no Ack, expected one within %0d cycles", maxc);
    end
  endtask

  task automatic wait_rv(input int maxc, output int d);
    d = -1;
    for (int i = 0; i < maxc && d < 0; i++) begin
      @(negedge Clock);
      if (ResultValid != '0) d = cyc - t_issue;
    end
    if (d < 0) begin
      checks++; errors++;
      $display("FAIL rv_wait: got no ResultValid, expected one within %0d cycles", maxc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    int g, d, rvc;
    int exp_g[5];
    logic [PW-1:0] exp_r[5];
    exp_g = '{0, 1, 2, 3, 0};
    exp_r = '{32'h0000000C, 32'hFFFFFFE2, 32'hFFFFFD44, 32'h00008000, 32'h0000000C};
    for (int i = 0; i < NREQ; i++) begin a_arr[i] = '0; b_arr[i] = '0; end

    // reset state
    @(posedge Clock); chk_en = 1'b1;
    @(negedge Clock); @(negedge Clock); Reset = 1'b0;
    @(negedge Clock);
    chk("rst_ack", 64'(Ack), 64'd0);
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_result", 64'(Result), 64'd0);
    chk("rst_mulstart", 64'(MulStart), 64'd0);

    // single request, done latency 6
    a_arr[1] = 16'h0007; b_arr[1] = 16'hFFFD; mul_lat = 6; Req = 4'b0010;
    wait_ack(10, g);
    chk("t1_ack", 64'(Ack), 64'h2);
    chk("t1_start", 64'(MulStart), 64'd1);
    chk("t1_mula", 64'(MulA), 64'h0007);
    chk("t1_mulb", 64'(MulB), 64'hFFFD);
    Req = '0;
    @(negedge Clock);
    chk("t1_ack_clr", 64'(Ack), 64'd0);
    chk("t1_start_clr", 64'(MulStart), 64'd0);
    wait_rv(20, d);
    chk("t1_latency", 64'(d), 64'd7);
    chk("t1_rv", 64'(ResultValid), 64'h2);
    chk("t1_result", 64'(Result), 64'hFFFFFFEB);
    chk("t1_error", 64'(Error), 64'd0);
    chk("t1_busy", 64'(Busy), 64'd0);
    @(negedge Clock);
    chk("t1_rv_clr", 64'(ResultValid), 64'd0);

    // contention: all four held from reset, done latency 3
    Reset = 1'b1; Req = 4'b1111; mul_lat = 3;
    a_arr[0] = 16'd3;    b_arr[0] = 16'd4;
    a_arr[1] = 16'hFFFB; b_arr[1] = 16'd6;
    a_arr[2] = 16'd100;  b_arr[2] = 16'hFFF9;
    a_arr[3] = 16'hFFFF; b_arr[3] = 16'h8000;
    @(negedge Clock);
    dut_gnt.delete(); mdl_gnt.delete(); ack_cyc.delete(); rv_res.delete();
    @(negedge Clock); Reset = 1'b0;
    for (int i = 0; i < 5; i++) wait_ack(20, g);
    Req = '0;
    wait_rv(20, d);
    chk("cont_latency", 64'(d), 64'd4);
    @(negedge Clock);
    chk("cont_ngrants", 64'(dut_gnt.size()), 64'd5);
    chk("cont_nresults", 64'(rv_res.size()), 64'd5);
    if (dut_gnt.size() == 5 && mdl_gnt.size() == 5 && rv_res.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        chk("cont_grant", 64'(dut_gnt[i]), 64'(exp_g[i]));
        chk("model_grant", 64'(mdl_gnt[i]), 64'(exp_g[i]));
        chk("cont_product", 64'(rv_res[i]), 64'(exp_r[i]));
      end
      for (int i = 0; i < 4; i++) chk("cont_spacing", 64'(ack_cyc[i+1] - ack_cyc[i]), 64'd5);
    end

    // wrap: serve 2, then 1001 gives 3 then 0
    Req = 4'b0100;
    wait_ack(10, g); chk("wrap_g2", 64'(g), 64'd2);
    Req = '0;
    wait_rv(20, d);
    Req = 4'b1001;
    wait_ack(10, g); chk("wrap_g3", 64'(g), 64'd3);
    wait_ack(20, g); chk("wrap_g0", 64'(g), 64'd0);
    Req = '0;
    wait_rv(20, d);

    // timeout, then a normal operation
    mul_lat = 0; Req = 4'b0010;
    wait_ack(10, g); Req = '0;
    wait_rv(100, d);
    chk("to_latency", 64'(d), 64'd65);
    chk("to_rv", 64'(ResultValid), 64'h2);
    chk("to_error", 64'(Error), 64'd1);
    chk("to_result", 64'(Result), 64'd0);
    mul_lat = 2; Req = 4'b0100;
    wait_ack(10, g); Req = '0;
    wait_rv(20, d);
    chk("post_to_latency", 64'(d), 64'd3);
    chk("post_to_error", 64'(Error), 64'd0);
    chk("post_to_result", 64'(Result), 64'hFFFFFD44);

    // done on the last WAIT cycle beats the watchdog
    a_arr[3] = 16'hFFFE; b_arr[3] = 16'h0003; mul_lat = 64; Req = 4'b1000;
    wait_ack(10, g); Req = '0;
    wait_rv(100, d);
    chk("coll_latency", 64'(d), 64'd65);
    chk("coll_rv", 64'(ResultValid), 64'h8);
    chk("coll_error", 64'(Error), 64'd0);
    chk("coll_result", 64'(Result), 64'hFFFFFFFA);

    // reset during WAIT cycle 3; the late done must be ignored
    mul_lat = 5; Req = 4'b0001;
    wait_ack(10, g); Req = '0;
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock); Reset = 1'b0;
    chk("mrst_ack", 64'(Ack), 64'd0);
    chk("mrst_rv", 64'(ResultValid), 64'd0);
    chk("mrst_result", 64'(Result), 64'd0);
    chk("mrst_error", 64'(Error), 64'd0);
    chk("mrst_busy", 64'(Busy), 64'd0);
    chk("mrst_start", 64'(MulStart), 64'd0);
    chk("mrst_mula", 64'(MulA), 64'd0);
    chk("mrst_mulb", 64'(MulB), 64'd0);
    rvc = 0;
    repeat (6) begin
      @(negedge Clock);
      if (ResultValid != '0) rvc++;
    end
    chk("mrst_no_rv", 64'(rvc), 64'd0);
    mul_lat = 1; Req = 4'b1111;
    wait_ack(10, g); chk("mrst_first_grant", 64'(g), 64'd0);
    Req = '0;
    wait_rv(20, d);
    chk("mrst_latency", 64'(d), 64'd2);
    repeat (3) @(negedge Clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
